std_div_arbiter: RTL and testbench



---
 rtl/std_div_arbiter.sv | 117 +++++++++++
 tb/tb_std_div_arbiter.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/std_div_arbiter.sv
// Round-robin arbiter sharing one bit-serial restoring divider among NREQ requesters.
// Optional macro STD_DIV_ARBITER_ZERO_ERR_EN adds a resp_err flag for zero divisors.
module std_div_arbiter #(
  parameter int WIDTH = 32,
  parameter int NREQ  = 4,
  parameter int IDW   = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*WIDTH-1:0] req_left,
  input  logic [NREQ*WIDTH-1:0] req_right,
  output logic [NREQ-1:0]       req_ready,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [IDW-1:0]        resp_id,
  output logic [WIDTH-1:0]      quotient,
  output logic [WIDTH-1:0]      remainder
`ifdef STD_DIV_ARBITER_ZERO_ERR_EN
  ,
  output logic                  resp_err
`endif
);

  localparam int CNTW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t            r_state, w_state_nxt;
  logic [IDW-1:0]    r_rr_ptr, w_win;
  logic              w_any, w_grant, w_last, w_ge;
  logic [WIDTH-1:0]  r_dvd, r_dvs, r_rem, w_win_left, w_win_right, w_rem_sub;
  logic [WIDTH:0]    w_rem_next;
  logic [CNTW-1:0]   r_cnt;

  // Scan downward so the lowest offset from the pointer is assigned last and wins.
  always_comb begin
    w_any = 1'b0;
    w_win = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (req_valid[(int'(r_rr_ptr) + k) % NREQ]) begin
        w_any = 1'b1;
        w_win = IDW'((int'(r_rr_ptr) + k) % NREQ);
      end
    end
  end

  assign w_grant     = (r_state == S_IDLE) && w_any && !reset;
  assign req_ready   = w_grant ? (NREQ'(1) << w_win) : '0;
  assign w_win_left  = req_left[int'(w_win)*WIDTH +: WIDTH];
  assign w_win_right = req_right[int'(w_win)*WIDTH +: WIDTH];
  assign resp_valid  = (r_state == S_DONE);

  // Compare is one bit wider than the operands so divisors >= 2^(WIDTH-1) cannot overflow.
  assign w_rem_next = {r_rem, r_dvd[WIDTH-1]};
  assign w_ge       = (w_rem_next >= {1'b0, r_dvs});
  assign w_rem_sub  = w_rem_next[WIDTH-1:0] - r_dvs;
  assign w_last     = (r_cnt == CNTW'(WIDTH - 1));

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_grant) w_state_nxt = (w_win_right == '0) ? S_DONE : S_RUN;
      S_RUN:   if (w_last) w_state_nxt = S_DONE;
      S_DONE:  if (resp_ready) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_rr_ptr  <= '0;
      r_dvd     <= '0;
      r_dvs     <= '0;
      r_rem     <= '0;
      r_cnt     <= '0;
      resp_id   <= '0;
      quotient  <= '0;
      remainder <= '0;
`ifdef STD_DIV_ARBITER_ZERO_ERR_EN
      resp_err  <= 1'b0;
`endif
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        S_IDLE: if (w_grant) begin
          r_rr_ptr <= IDW'((int'(w_win) + 1) % NREQ);
          r_dvd    <= w_win_left;
          r_dvs    <= w_win_right;
          r_rem    <= '0;
          r_cnt    <= '0;
          resp_id  <= w_win;
          if (w_win_right == '0) begin
            quotient  <= '1;
            remainder <= w_win_left;
          end
`ifdef STD_DIV_ARBITER_ZERO_ERR_EN
          resp_err <= (w_win_right == '0);
`endif
        end
        S_RUN: begin
          // The dividend register doubles as the quotient shift register.
          r_dvd <= {r_dvd[WIDTH-2:0], w_ge};
          r_rem <= w_ge ? w_rem_sub : w_rem_next[WIDTH-1:0];
          r_cnt <= r_cnt + 1'b1;
          if (w_last) begin
            quotient  <= {r_dvd[WIDTH-2:0], w_ge};
            remainder <= w_ge ? w_rem_sub : w_rem_next[WIDTH-1:0];
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_std_div_arbiter.sv
// Directed testbench for std_div_arbiter (WIDTH=32, NREQ=4).
module tb_std_div_arbiter;

  logic         clk = 1'b0;
  logic         reset;
  logic [3:0]   req_valid, req_ready;
  logic [127:0] req_left, req_right;
  logic         resp_valid, resp_ready;
  logic [1:0]   resp_id;
  logic [31:0]  quotient, remainder;
`ifdef STD_DIV_ARBITER_ZERO_ERR_EN
  logic         resp_err;
`endif

  int checks = 0;
  int errors = 0;

  std_div_arbiter #(.WIDTH(32), .NREQ(4)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_left(req_left),
    .req_right(req_right), .req_ready(req_ready), .resp_valid(resp_valid),
    .resp_ready(resp_ready), .resp_id(resp_id), .quotient(quotient),
    .remainder(remainder)
`ifdef STD_DIV_ARBITER_ZERO_ERR_EN
    , .resp_err(resp_err)
`endif
  );

  always #5 clk = ~clk;

  task automatic set_op(input int i, input logic [31:0] l, input logic [31:0] r);
    req_left[i*32 +: 32]  = l;
    req_right[i*32 +: 32] = r;
  endtask

  task automatic grant(input logic [3:0] v, output logic [3:0] rdy);
    @(negedge clk);
    req_valid = v;
    #1 rdy = req_ready;
  endtask

  // Counts cycles after the accept edge until resp_valid; 200 means it never came.
  task automatic wait_resp(input bit drop, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (drop && n == 1) req_valid = '0;
    end while (!resp_valid && n < 200);
  endtask

  task automatic hs();
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; req_valid = 4'hF; resp_ready = 1'b0;
    req_left = '0; req_right = '0;
    repeat (3) @(negedge clk);
    #1;
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL rst_ready got=%b exp=0000", req_ready); end
    checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got=%b exp=0", resp_valid); end
    checks++; if (quotient !== 32'd0) begin errors++; $display("FAIL rst_q got=%0h exp=0", quotient); end
    checks++; if (remainder !== 32'd0) begin errors++; $display("FAIL rst_r got=%0h exp=0", remainder); end
    checks++; if (resp_id !== 2'd0) begin errors++; $display("FAIL rst_id got=%0d exp=0", resp_id); end
`ifdef STD_DIV_ARBITER_ZERO_ERR_EN
    checks++; if (resp_err !== 1'b0) begin errors++; $display("FAIL rst_err got=%b exp=0", resp_err); end
`endif
    req_valid = '0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_single();
    logic [3:0] rdy; int n;
    set_op(0, 32'd100, 32'd7);
    grant(4'b0001, rdy);
    checks++; if (rdy !== 4'b0001) begin errors++; $display("FAIL single_ready got=%b exp=0001", rdy); end
    wait_resp(1'b1, n);
    checks++; if (n !== 33) begin errors++; $display("FAIL single_latency got=%0d exp=33", n); end
    checks++; if (quotient !== 32'd14) begin errors++; $display("FAIL single_q got=%0d exp=14", quotient); end
    checks++; if (remainder !== 32'd2) begin errors++; $display("FAIL single_r got=%0d exp=2", remainder); end
    checks++; if (resp_id !== 2'd0) begin errors++; $display("FAIL single_id got=%0d exp=0", resp_id); end
`ifdef STD_DIV_ARBITER_ZERO_ERR_EN
    checks++; if (resp_err !== 1'b0) begin errors++; $display("FAIL single_err got=%b exp=0", resp_err); end
`endif
    hs();
    checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL single_idle got=%b exp=0", resp_valid); end
  endtask

  task automatic test_fairness();
    logic [3:0] rdy; int n;
    logic [31:0] eq [4];
    logic [31:0] er [4];
    logic [1:0]  eid [5];
    eq[0] = 32'd11;         er[0] = 32'd0;
    eq[1] = 32'd0;          er[1] = 32'd9;
    eq[2] = 32'hFFFFFFFF;   er[2] = 32'd0;
    eq[3] = 32'd0;          er[3] = 32'h80000000;
    eid[0] = 2'd0; eid[1] = 2'd1; eid[2] = 2'd2; eid[3] = 2'd3; eid[4] = 2'd0;
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    set_op(0, 32'd55, 32'd5);
    set_op(1, 32'd9, 32'd10);
    set_op(2, 32'hFFFFFFFF, 32'd1);
    set_op(3, 32'h80000000, 32'hFFFFFFFF);
    resp_ready = 1'b1;
    grant(4'hF, rdy);
    checks++; if (rdy !== 4'b0001) begin errors++; $display("FAIL fair_ready got=%b exp=0001", rdy); end
    for (int i = 0; i < 5; i++) begin
      wait_resp(1'b0, n);
      if (i == 4) req_valid = '0;
      checks++; if (resp_id !== eid[i]) begin errors++; $display("FAIL fair_id[%0d] got=%0d exp=%0d", i, resp_id, eid[i]); end
      checks++; if (quotient !== eq[eid[i]] || remainder !== er[eid[i]])
        begin errors++; $display("FAIL fair_qr[%0d] got=%0h/%0h exp=%0h/%0h", i, quotient, remainder, eq[eid[i]], er[eid[i]]); end
    end
    @(negedge clk);
    resp_ready = 1'b0;
  endtask

  task automatic test_div_zero();
    logic [3:0] rdy; int n;
    set_op(1, 32'd123, 32'd0);
    grant(4'b0010, rdy);
    checks++; if (rdy !== 4'b0010) begin errors++; $display("FAIL dz_ready got=%b exp=0010", rdy); end
    wait_resp(1'b1, n);
    checks++; if (n !== 1) begin errors++; $display("FAIL dz_latency got=%0d exp=1", n); end
    checks++; if (quotient !== 32'hFFFFFFFF) begin errors++; $display("FAIL dz_q got=%0h exp=ffffffff", quotient); end
    checks++; if (remainder !== 32'd123) begin errors++; $display("FAIL dz_r got=%0d exp=123", remainder); end
    checks++; if (resp_id !== 2'd1) begin errors++; $display("FAIL dz_id got=%0d exp=1", resp_id); end
`ifdef STD_DIV_ARBITER_ZERO_ERR_EN
    checks++; if (resp_err !== 1'b1) begin errors++; $display("FAIL dz_err got=%b exp=1", resp_err); end
`endif
    hs();
  endtask

  task automatic test_backpressure();
    logic [3:0] rdy; int n; int bad;
    set_op(2, 32'd1000, 32'd3);
    set_op(3, 32'd50, 32'd8);
    grant(4'b0100, rdy);
    checks++; if (rdy !== 4'b0100) begin errors++; $display("FAIL bp_ready got=%b exp=0100", rdy); end
    wait_resp(1'b1, n);
    checks++; if (n !== 33) begin errors++; $display("FAIL bp_latency got=%0d exp=33", n); end
    checks++; if (quotient !== 32'd333 || remainder !== 32'd1 || resp_id !== 2'd2)
      begin errors++; $display("FAIL bp_result got=%0d/%0d/%0d exp=333/1/2", quotient, remainder, resp_id); end
    req_valid = 4'b1000;
    bad = 0;
    repeat (10) begin
      @(negedge clk); #1;
      if (resp_valid !== 1'b1 || quotient !== 32'd333 || remainder !== 32'd1 ||
          resp_id !== 2'd2 || req_ready !== 4'b0000) bad++;
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL bp_hold got=%0d bad cycles exp=0", bad); end
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    #1;
    checks++; if (req_ready !== 4'b1000 || resp_valid !== 1'b0)
      begin errors++; $display("FAIL bp_regrant got=%b/%b exp=1000/0", req_ready, resp_valid); end
    wait_resp(1'b1, n);
    checks++; if (n !== 33 || quotient !== 32'd6 || remainder !== 32'd2 || resp_id !== 2'd3)
      begin errors++; $display("FAIL bp_second got=%0d:%0d/%0d/%0d exp=33:6/2/3", n, quotient, remainder, resp_id); end
    hs();
  endtask

  task automatic test_reset_mid_run();
    logic [3:0] rdy; int n; int bad;
    set_op(2, 32'd77, 32'd7);
    grant(4'b0100, rdy);
    checks++; if (rdy !== 4'b0100) begin errors++; $display("FAIL mr_ready got=%b exp=0100", rdy); end
    @(negedge clk); req_valid = '0;
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk); #1;
    checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL mr_valid got=%b exp=0", resp_valid); end
    reset = 1'b0;
    bad = 0;
    repeat (40) begin @(negedge clk); if (resp_valid !== 1'b0) bad++; end
    checks++; if (bad !== 0) begin errors++; $display("FAIL mr_noresp got=%0d exp=0", bad); end
    // Pointer back at 0 means requester 2 beats requester 3.
    grant(4'b1100, rdy);
    checks++; if (rdy !== 4'b0100) begin errors++; $display("FAIL mr_ptr got=%b exp=0100", rdy); end
    wait_resp(1'b1, n);
    checks++; if (n !== 33 || quotient !== 32'd11 || remainder !== 32'd0 || resp_id !== 2'd2)
      begin errors++; $display("FAIL mr_rereq got=%0d:%0d/%0d/%0d exp=33:11/0/2", n, quotient, remainder, resp_id); end
    hs();
  endtask

  task automatic test_ptr_wrap();
    logic [3:0] rdy; int n;
    set_op(0, 32'd100, 32'd7);
    grant(4'b1000, rdy);
    checks++; if (rdy !== 4'b1000) begin errors++; $display("FAIL wrap_g3 got=%b exp=1000", rdy); end
    wait_resp(1'b1, n);
    checks++; if (resp_id !== 2'd3 || quotient !== 32'd6) begin errors++; $display("FAIL wrap_r3 got=%0d/%0d exp=3/6", resp_id, quotient); end
    hs();
    grant(4'b1001, rdy);
    checks++; if (rdy !== 4'b0001) begin errors++; $display("FAIL wrap_g0 got=%b exp=0001", rdy); end
    wait_resp(1'b1, n);
    checks++; if (resp_id !== 2'd0 || quotient !== 32'd14 || remainder !== 32'd2)
      begin errors++; $display("FAIL wrap_r0 got=%0d/%0d/%0d exp=0/14/2", resp_id, quotient, remainder); end
    hs();
    grant(4'b1001, rdy);
    checks++; if (rdy !== 4'b1000) begin errors++; $display("FAIL wrap_g3b got=%b exp=1000", rdy); end
    wait_resp(1'b1, n);
    checks++; if (resp_id !== 2'd3) begin errors++; $display("FAIL wrap_r3b got=%0d exp=3", resp_id); end
    hs();
  endtask

  initial begin
    test_reset();
    test_single();
    test_fairness();
    test_div_zero();
    test_backpressure();
    test_reset_mid_run();
    test_ptr_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, errors);
    $finish;
  end

endmodule
